// File: rtl/game_pkg.sv
// Shared game-flow types: phase encoding and sound-event selectors used by the
// flow controller, the sound block and the renderer.
package game_pkg;

  typedef enum logic [2:0] {
    MENU        = 3'd0,
    PLAYING     = 3'd1,
    DYING       = 3'd2,
    LEVEL_CLEAR = 3'd3,
    GAME_OVER   = 3'd4,
    WIN         = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    UI_PRESS    = 2'd0,
    NEXTLEVEL   = 2'd1,
    CRASH       = 2'd2,
    CELEBRATION = 2'd3
  } sound_t;

endpackage

// File: rtl/hold_timer.sv
// Down-counting residency timer: load starts a CYCLES-long hold, and done is
// high during the last cycle of that hold.
module hold_timer #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic busy,
  output logic done
);

  localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      busy  <= 1'b0;
    end else if (load) begin
      count <= CNT_W'(CYCLES - 1);
      busy  <= 1'b1;
    end else if (busy) begin
      if (count == '0) busy  <= 1'b0;
      else             count <= count - 1'b1;
    end
  end

  assign done = busy && (count == '0);

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow controller: menu/play/death/level-clear/game-over/win phases, level
// and lives counters, timed holds, and one-cycle sound/round pulses.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter  int NUM_LEVELS  = 4,
  parameter  int NUM_LIVES   = 3,
  parameter  int HOLD_CYCLES = 25000000,
  localparam int LEVEL_W     = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  localparam int LIVES_W     = $clog2(NUM_LIVES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         dpad_input,
  input  logic               collision,
  input  logic               reached_end,
  output logic [2:0]         state,
  output logic [LEVEL_W-1:0] level,
  output logic [LIVES_W-1:0] lives,
  output logic [1:0]         sound_sel,
  output logic               sound_play,
  output logic               win_pulse,
  output logic               lose_pulse,
  output logic               round_reset
);

  localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [LIVES_W-1:0] FULL_LIVES = LIVES_W'(NUM_LIVES);

  state_t             state_q, state_nx;
  logic [LEVEL_W-1:0] level_q, level_nx;
  logic [LIVES_W-1:0] lives_q, lives_nx;
  sound_t             sound_q, sound_nx;
  logic               play_nx, win_nx, lose_nx, round_nx;
  logic [3:0]         prev_dpad;
  logic               press;
  logic               timer_load, timer_busy, timer_done, hold_over;

  hold_timer #(.CYCLES(HOLD_CYCLES)) u_hold_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .busy  (timer_busy),
    .done  (timer_done)
  );

  // prev_dpad resets to all-ones so a button held through reset is not a press.
  assign press     = (dpad_input != 4'h0) && (prev_dpad == 4'h0);
  assign hold_over = timer_done || !timer_busy;

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx   = state_q;
    level_nx   = level_q;
    lives_nx   = lives_q;
    sound_nx   = sound_q;
    play_nx    = 1'b0;
    win_nx     = 1'b0;
    lose_nx    = 1'b0;
    round_nx   = 1'b0;
    timer_load = 1'b0;
    unique case (state_q)
      MENU: if (press) begin
        state_nx = PLAYING;
        level_nx = '0;
        lives_nx = FULL_LIVES;
        sound_nx = UI_PRESS;
        play_nx  = 1'b1;
        round_nx = 1'b1;
      end
      PLAYING: if (collision) begin
        state_nx   = DYING;
        lives_nx   = (lives_q != '0) ? lives_q - 1'b1 : '0;
        sound_nx   = CRASH;
        play_nx    = 1'b1;
        lose_nx    = 1'b1;
        timer_load = 1'b1;
      end else if (reached_end) begin
        play_nx = 1'b1;
        if (level_q == LAST_LEVEL) begin
          state_nx = WIN;
          sound_nx = CELEBRATION;
          win_nx   = 1'b1;
        end else begin
          state_nx   = LEVEL_CLEAR;
          level_nx   = level_q + 1'b1;
          sound_nx   = NEXTLEVEL;
          timer_load = 1'b1;
        end
      end
      DYING: if (hold_over) begin
        if (lives_q == '0) begin
          state_nx = GAME_OVER;
        end else begin
          state_nx = PLAYING;
          round_nx = 1'b1;
        end
      end
      LEVEL_CLEAR: if (hold_over) begin
        state_nx = PLAYING;
        round_nx = 1'b1;
      end
      GAME_OVER, WIN: if (press) begin
        state_nx = MENU;
        sound_nx = UI_PRESS;
        play_nx  = 1'b1;
      end
      default: state_nx = MENU;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= MENU;
      level_q     <= '0;
      lives_q     <= FULL_LIVES;
      sound_q     <= UI_PRESS;
      sound_play  <= 1'b0;
      win_pulse   <= 1'b0;
      lose_pulse  <= 1'b0;
      round_reset <= 1'b0;
      prev_dpad   <= 4'hF;
    end else begin
      state_q     <= state_nx;
      level_q     <= level_nx;
      lives_q     <= lives_nx;
      sound_q     <= sound_nx;
      sound_play  <= play_nx;
      win_pulse   <= win_nx;
      lose_pulse  <= lose_nx;
      round_reset <= round_nx;
      prev_dpad   <= dpad_input;
    end
  end

  assign state     = state_q;
  assign level     = level_q;
  assign lives     = lives_q;
  assign sound_sel = sound_q;

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Parametrised top-level game-flow controller for the frogger datapath. It tracks menu/play/death/level-clear/game-over/win phases, a multi-level counter and a lives counter, and timed hold phases. It issues one-cycle sound-event pulses and a round_reset pulse that re-spawns the frog and lanes. It sits between the input/collision logic and the renderer/sound blocks.

Parameters:
NUM_LEVELS, 4, number of levels; clearing level NUM_LEVELS-1 wins the game (>=1)
NUM_LIVES, 3, lives at game start (>=1)
HOLD_CYCLES, 25000000, clk cycles spent in DYING and in LEVEL_CLEAR (>=1)
LEVEL_W, $clog2(NUM_LEVELS) (min 1), level output width, derived
LIVES_W, $clog2(NUM_LIVES+1), lives output width, derived

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
dpad_input  in  4  raw d-pad buttons, one bit per direction
collision  in  1  frog hit a hazard (level-sensitive, sampled each cycle)
reached_end  in  1  frog reached the goal row
state  out  3  current game_pkg::state_t
level  out  LEVEL_W  current level, 0-based
lives  out  LIVES_W  remaining lives
sound_sel  out  2  game_pkg::sound_t of the last event; held until the next event
sound_play  out  1  one-cycle pulse; sound_sel is valid in the same cycle
win_pulse  out  1  one-cycle pulse on entry to WIN
lose_pulse  out  1  one-cycle pulse on every life lost
round_reset  out  1  one-cycle pulse whenever PLAYING is (re)entered

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high.
- Reset values: state=MENU, level=0, lives=NUM_LIVES, sound_sel=UI_PRESS; all pulses 0; timer 0; prev_dpad=4'hF.
- Reset is honoured in any state and mid-hold, overriding all other events.
- Press detection:
  - press = (dpad_input!=0) && (prev_dpad==0); prev_dpad is registered every cycle.
  - A button held through reset, or held across states, never counts as a press. The button must be released first.
- Outputs are registered, with 1-cycle latency. A stimulus sampled at edge N shows the new state and its pulses after edge N, and the pulses drop after edge N+1.
- MENU:
  - press -> PLAYING; level=0, lives=NUM_LIVES, sound UI_PRESS, round_reset.
  - collision and reached_end are ignored.
- PLAYING:
  - collision has priority over reached_end in the same cycle.
  - collision -> DYING; lives decrements, saturating at 0; lose_pulse; sound CRASH; load timer.
  - reached_end with level==NUM_LEVELS-1 -> WIN; win_pulse; sound CELEBRATION.
  - reached_end otherwise -> LEVEL_CLEAR; level+1; sound NEXTLEVEL; load timer.
- DYING:
  - All inputs are ignored.
  - On timer expiry: lives==0 -> GAME_OVER; else -> PLAYING with round_reset. level is unchanged.
- LEVEL_CLEAR: inputs are ignored; on timer expiry -> PLAYING with round_reset.
- GAME_OVER and WIN: press -> MENU with sound UI_PRESS. level and lives keep their values for display until the next game starts.
- Hold timer:
  - Loaded with HOLD_CYCLES-1 on the entry edge, then decrements once per cycle.
  - Expiry is when it reads 0, giving exactly HOLD_CYCLES cycles of residency.
  - HOLD_CYCLES=1 gives a single-cycle hold.
- Simultaneous sound events cannot occur: at most one transition happens per cycle, so at most one sound_play per cycle.
- Width rules: level never exceeds NUM_LEVELS-1; lives never underflows. No wrap-around on either.

Decomposition:
- Package game_pkg:
  - state_t enum logic[2:0]: MENU=0, PLAYING=1, DYING=2, LEVEL_CLEAR=3, GAME_OVER=4, WIN=5.
  - sound_t enum logic[1:0]: UI_PRESS=0, NEXTLEVEL=1, CRASH=2, CELEBRATION=3.
  - Shared with the sound and render blocks.
- Sub-module hold_timer, parameter CYCLES: ports load, busy, done. Counter width is $clog2(CYCLES) (min 1). Reusable for other timed effects.

Test Plan (NUM_LEVELS=3, NUM_LIVES=2, HOLD_CYCLES=4):
- Held start: hold dpad=4'b0001 through reset and 10 cycles -> state stays MENU. Release, then press -> PLAYING; sound_play=1 with sound_sel=0; round_reset=1 for one cycle; level=0, lives=2.
- Death then re-spawn: collision for 1 cycle -> DYING, lives=1, lose_pulse and sound_sel=2 for one cycle. Exactly 4 cycles later -> PLAYING with round_reset.
- Game over: a second collision -> lives=0; after 4 cycles -> GAME_OVER. collision now ignored. Press -> MENU with sound_sel=0.
- Win path: reached_end three times, waiting out each LEVEL_CLEAR -> level goes 1, 2 with sound_sel=1. The third reached_end -> WIN, win_pulse, sound_sel=3; level stays 2.
- Priority: collision and reached_end asserted in the same PLAYING cycle -> DYING; level unchanged, no NEXTLEVEL sound.
- Reset mid-hold: assert reset on the 2nd cycle of LEVEL_CLEAR -> next cycle state=MENU, level=0, lives=2, no pulses.
